// File: rtl/vga_pkg.sv
// Shared VGA timing constants and controller state encoding, reused by the
// cursor generator and the downstream sync/porch stage.
package vga_pkg;
  localparam int TOTAL_COL  = 800;
  localparam int TOTAL_ROW  = 525;
  localparam int ACTIVE_COL = 640;
  localparam int ACTIVE_ROW = 480;
  localparam int CUR_W      = 10;
  localparam int PRE_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;
endpackage

// File: rtl/pix_strobe_div.sv
// Pixel prescaler: counts 0..CLK_DIV-1 while the generator is active and
// flags the edge at which the count reaches its last value.
module pix_strobe_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  input  logic run,
  output logic tick
);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre, pre_nxt;

  // tick is independent of run so the controller can use it to decide
  // whether this edge ends the drain without a combinational loop.
  always_comb begin
    pre_nxt = '0;
    if (adv) pre_nxt = (pre == LAST) ? '0 : pre + PRE_W'(1);
  end

  assign tick = (pre_nxt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre <= '0;
    else        pre <= run ? pre_nxt : '0;
  end
endmodule

// File: rtl/vga_cursor_gen.sv
// VGA raster cursor generator: X/Y scan position, pixel strobe, line/frame
// markers and a completed-frame counter with IDLE/RUN/DRAIN control.
module vga_cursor_gen
  import vga_pkg::*;
#(
  parameter int total_col  = TOTAL_COL,
  parameter int total_row  = TOTAL_ROW,
  parameter int active_col = ACTIVE_COL,
  parameter int active_row = ACTIVE_ROW,
  parameter int CLK_DIV    = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_En,
  output logic [CUR_W-1:0] o_X_Cursor,
  output logic [CUR_W-1:0] o_Y_Cursor,
  output logic             o_Pix_Stb,
  output logic             o_Active,
  output logic             o_Line_Start,
  output logic             o_Frame_Start,
  output logic [7:0]       o_Frame_Count,
  output logic             o_Busy
);
  localparam logic [CUR_W-1:0] X_LAST = CUR_W'(total_col - 1);
  localparam logic [CUR_W-1:0] Y_LAST = CUR_W'(total_row - 1);
  localparam logic [CUR_W-1:0] X_ACT  = CUR_W'(active_col);
  localparam logic [CUR_W-1:0] Y_ACT  = CUR_W'(active_row);

  vga_state_e       state, state_nxt;
  logic             tick, stb, fresh, x_wrap, y_wrap, drain_done;
  logic             ls, fs, cnt_inc, going;
  logic [CUR_W-1:0] x_nxt, y_nxt;

  assign x_wrap = (o_X_Cursor == X_LAST);
  assign y_wrap = (o_Y_Cursor == Y_LAST);

  pix_strobe_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .adv   (state != ST_IDLE),
    .run   (going),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_En) state_nxt = ST_RUN;
      ST_RUN:   if (!i_En) state_nxt = ST_DRAIN;
      ST_DRAIN: if (i_En) state_nxt = ST_RUN;
                else if (tick && x_wrap && y_wrap) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign going      = (state_nxt != ST_IDLE);
  assign stb        = tick && going;
  assign drain_done = (state == ST_DRAIN) && !going;

  // The first strobe after leaving IDLE presents 0,0 instead of advancing.
  always_comb begin
    x_nxt   = o_X_Cursor;
    y_nxt   = o_Y_Cursor;
    ls      = 1'b0;
    fs      = 1'b0;
    cnt_inc = 1'b0;
    if (drain_done) begin
      x_nxt   = '0;
      y_nxt   = '0;
      cnt_inc = 1'b1;
    end else if (stb) begin
      if (fresh) begin
        x_nxt = '0;
        y_nxt = '0;
        ls    = 1'b1;
        fs    = 1'b1;
      end else if (x_wrap) begin
        x_nxt = '0;
        ls    = 1'b1;
        if (y_wrap) begin
          y_nxt   = '0;
          fs      = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          y_nxt = o_Y_Cursor + CUR_W'(1);
        end
      end else begin
        x_nxt = o_X_Cursor + CUR_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state         <= ST_IDLE;
      fresh         <= 1'b1;
      o_X_Cursor    <= '0;
      o_Y_Cursor    <= '0;
      o_Pix_Stb     <= 1'b0;
      o_Active      <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Frame_Count <= '0;
      o_Busy        <= 1'b0;
    end else begin
      state         <= state_nxt;
      fresh         <= !going ? 1'b1 : (stb ? 1'b0 : fresh);
      o_X_Cursor    <= x_nxt;
      o_Y_Cursor    <= y_nxt;
      o_Pix_Stb     <= stb;
      o_Active      <= going && (x_nxt < X_ACT) && (y_nxt < Y_ACT);
      o_Line_Start  <= ls;
      o_Frame_Start <= fs;
      o_Frame_Count <= o_Frame_Count + 8'(cnt_inc);
      o_Busy        <= going;
    end
  end
endmodule

// File: tb/tb_vga_cursor_gen.sv
// Scoreboard bench for vga_cursor_gen on a shrunken raster (20x8, 12x5 active):
// CLK_DIV=2 instance checked per strobe from a queue, CLK_DIV=1 instance per cycle.
module tb_vga_cursor_gen;
  localparam int TC = 20, TR = 8, AC = 12, AR = 5, F = TC * TR;

  typedef struct {
    int x; int y; int act; int ls; int fs; int cnt;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0, en_a = 1'b0, en_b = 1'b0;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       stb_a, act_a, ls_a, fs_a, busy_a;
  logic       stb_b, act_b, ls_b, fs_b, busy_b;
  logic [7:0] cnt_a, cnt_b;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0, n_stb = 0, cyc = 0, seg = 0, last_stb_cyc = 0;

  vga_cursor_gen #(.total_col(TC), .total_row(TR), .active_col(AC), .active_row(AR), .CLK_DIV(2)) u_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en_a), .o_X_Cursor(x_a), .o_Y_Cursor(y_a),
    .o_Pix_Stb(stb_a), .o_Active(act_a), .o_Line_Start(ls_a), .o_Frame_Start(fs_a),
    .o_Frame_Count(cnt_a), .o_Busy(busy_a));

  vga_cursor_gen #(.total_col(TC), .total_row(TR), .active_col(AC), .active_row(AR), .CLK_DIV(1)) u_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en_b), .o_X_Cursor(x_b), .o_Y_Cursor(y_b),
    .o_Pix_Stb(stb_b), .o_Active(act_b), .o_Line_Start(ls_b), .o_Frame_Start(fs_b),
    .o_Frame_Count(cnt_b), .o_Busy(busy_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pixel k of a run: raster position is plain division of the strobe index.
  task automatic push_seg(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.x   = k % TC;
      e.y   = (k / TC) % TR;
      e.act = int'(e.x < AC && e.y < AR);
      e.ls  = int'(e.x == 0);
      e.fs  = int'(e.x == 0 && e.y == 0);
      e.cnt = (base + k / F) % 256;
      q.push_back(e);
    end
  endtask

  task automatic wait_n(input string tag, input int target, input int budget);
    int i = 0;
    while (n_stb < target && i < budget) begin
      @(posedge clk); #2; i++;
    end
    chk(tag, int'(n_stb >= target), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    do begin
      @(posedge clk); #1; i++;
    end while (busy_a && i < budget);
    chk(tag, int'(busy_a), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Strobe monitor for the CLK_DIV=2 instance.
  initial begin
    int mon_seg = 0, gap = 0;
    bit have_prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (seg != mon_seg) begin mon_seg = seg; have_prev = 0; end
      gap++;
      if (rst_n && stb_a) begin
        if (have_prev) chk("stb_gap", gap, 2);
        have_prev = 1; gap = 0; last_stb_cyc = cyc; n_stb++;
        if (q.size() == 0) chk("extra_stb", 1, 0);
        else begin
          e = q.pop_front();
          chk("x", int'(x_a), e.x);
          chk("y", int'(y_a), e.y);
          chk("active", int'(act_a), e.act);
          chk("line_start", int'(ls_a), e.ls);
          chk("frame_start", int'(fs_a), e.fs);
          chk("frame_count", int'(cnt_a), e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", int'(x_a), 0);
    chk("rst_stb", int'(stb_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);

    push_seg(3 * F, 0);
    @(negedge clk);
    rst_n = 1'b1; en_a = 1'b1; en_b = 1'b1;
    fork
      begin
        @(posedge clk); #1;
        chk("c1_stb", int'(stb_a), 0);
        chk("c1_busy", int'(busy_a), 1);
        @(posedge clk); #1;
        chk("c2_stb", int'(stb_a), 1);
        chk("c2_fs", int'(fs_a), 1);
        chk("c2_act", int'(act_a), 1);
      end
      begin
        for (int c = 1; c <= 30; c++) begin
          int ex, ey;
          @(posedge clk); #1;
          ex = (c - 1) % TC; ey = (c - 1) / TC;
          chk("b_stb", int'(stb_b), 1);
          chk("b_x", int'(x_b), ex);
          chk("b_y", int'(y_b), ey);
          chk("b_ls", int'(ls_b), int'(ex == 0));
          chk("b_fs", int'(fs_b), int'(ex == 0 && ey == 0));
          chk("b_act", int'(act_b), int'(ex < AC && ey < AR));
          chk("b_busy_cnt", int'(busy_b) * 256 + int'(cnt_b), 256);
        end
      end
    join

    // Brief DRAIN mid-frame, then resume: scoreboard demands continuity.
    wait_n("wait_mid", F + 30, 4 * F);
    en_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("drain_busy", int'(busy_a), 1);
    repeat (3) @(posedge clk);
    #1 en_a = 1'b1;

    // Drop enable at Y=3 of the third frame; drain runs to the frame end.
    wait_n("wait_drop", 2 * F + 3 * TC + 1, 4 * F);
    en_a = 1'b0;
    wait_idle("drain_idle", 6 * F);
    chk("idle_after_last", cyc - last_stb_cyc, 2);
    chk("idle_strobes", n_stb, 3 * F);
    chk("idle_cnt", int'(cnt_a), 3);
    chk("idle_xy", int'(x_a) + int'(y_a), 0);
    chk("idle_act", int'(act_a), 0);
    chk("idle_q", q.size(), 0);
    repeat (5) @(posedge clk);
    #1 chk("idle_stb", int'(stb_a), 0);

    // Restart from IDLE (count continues), then reset at X=7,Y=2.
    seg++;
    base = n_stb;
    push_seg(2 * TC + 20, 3);
    en_a = 1'b1;
    wait_n("wait_rst", base + 2 * TC + 8, 4 * F);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_x", int'(x_a), 0);
    chk("arst_y", int'(y_a), 0);
    chk("arst_stb", int'(stb_a), 0);
    chk("arst_act", int'(act_a), 0);
    chk("arst_ls_fs", int'(ls_a) + int'(fs_a), 0);
    chk("arst_cnt", int'(cnt_a), 0);
    chk("arst_busy", int'(busy_a), 0);
    q.delete();
    seg++;
    push_seg(2 * F, 0);
    repeat (2) @(negedge clk);
    base = n_stb;
    rst_n = 1'b1;
    wait_n("wait_frame", base + F + 1, 4 * F);
    en_a = 1'b0;
    wait_idle("rst_idle", 6 * F);
    chk("rst_frames", int'(cnt_a), 2);
    chk("rst_q", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_cursor_gen.md
VGA_CURSOR_GEN -- requirements
Module: vga_cursor_gen

Interface
REQ-001 SHALL have parameter total_col, default 800: pixel clocks per line, counts 0..total_col-1.
REQ-002 SHALL have parameter total_row, default 525: lines per frame, counts 0..total_row-1.
REQ-003 SHALL have parameter active_col, default 640: visible columns.
REQ-004 SHALL have parameter active_row, default 480: visible rows.
REQ-005 SHALL have parameter CLK_DIV, default 2: i_Clk cycles per pixel, range 1..15.
REQ-006 SHALL have port i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_En  input  1  run request; level-sensitive.
REQ-009 SHALL have port o_X_Cursor  output  10  current column; feeds the sync/porch stage.
REQ-010 SHALL have port o_Y_Cursor  output  10  current row; feeds the sync/porch stage.
REQ-011 SHALL have port o_Pix_Stb  output  1  one-i_Clk pulse marking each pixel advance.
REQ-012 SHALL have port o_Active  output  1  high when X < active_col and Y < active_row.
REQ-013 SHALL have port o_Line_Start  output  1  pulse coincident with the o_Pix_Stb that loads X=0.
REQ-014 SHALL have port o_Frame_Start  output  1  pulse coincident with the o_Pix_Stb that loads X=0,Y=0.
REQ-015 SHALL have port o_Frame_Count  output  8  completed-frame counter.
REQ-016 SHALL have port o_Busy  output  1  high in RUN and DRAIN states.

Function
REQ-017 SHALL use a prescaler counting 0..CLK_DIV-1 while running; o_Pix_Stb is asserted in the cycle in which the prescaler equals CLK_DIV-1. With CLK_DIV=1, o_Pix_Stb is continuously high while running.
REQ-018 SHALL, on each o_Pix_Stb, increment X; X = total_col-1 wraps to 0 and increments Y; Y = total_row-1 with that wrap sets Y to 0.
REQ-019 SHALL register all outputs; o_Active, o_Line_Start and o_Frame_Start SHALL reflect the cursor values presented in the same cycle (zero skew to X/Y).
REQ-020 SHALL implement states IDLE, RUN and DRAIN.
REQ-021 SHALL, in IDLE, hold X=0, Y=0, prescaler 0, o_Pix_Stb=0; i_En=1 moves to RUN, and the first strobe CLK_DIV cycles later SHALL present X=0,Y=0 with o_Frame_Start=1.
REQ-022 SHALL, in RUN with i_En=0, move to DRAIN; counting continues unchanged.
REQ-023 SHALL, in DRAIN with i_En=1, return to RUN without a cursor discontinuity.
REQ-024 SHALL, in DRAIN, return to IDLE on the strobe that would wrap X=total_col-1,Y=total_row-1; that wrap SHALL NOT assert o_Frame_Start but SHALL increment o_Frame_Count.
REQ-025 SHALL increment o_Frame_Count, modulo 256, on every Y wrap to 0 (completed frame).
REQ-026 SHALL hold o_Active=0 in IDLE.

Reset
REQ-027 SHALL, while i_Rst_n=0, force state IDLE and all outputs plus the prescaler to 0, independent of i_Clk.
REQ-028 SHALL, on reset assertion mid-frame, abandon the frame; after release, o_Frame_Count stays 0 until a full frame completes.

Structure
REQ-029 SHALL place the state encoding and the default timing constants (800/525/640/480) in a shared vga_pkg for reuse by the sync/porch stage.
REQ-030 SHALL be one module; the prescaler MAY be a sub-module named pix_strobe_div.

Verification
REQ-031 Reset release, i_En=1, CLK_DIV=2: first o_Pix_Stb at cycle 2 with X=0,Y=0, o_Frame_Start=1, o_Active=1.
REQ-032 Run to X=639 -> next strobe X=640, o_Active=0; X=799 -> next strobe X=0, Y+1, o_Line_Start=1.
REQ-033 Full frame of 800*525 strobes -> X=0,Y=0, o_Frame_Start=1, o_Frame_Count=1.
REQ-034 i_En dropped at Y=100 -> o_Busy stays 1 until after the strobe at X=799,Y=524, then IDLE, o_Frame_Count incremented, X=Y=0.
REQ-035 i_Rst_n pulsed low at X=300,Y=200 -> all outputs 0 immediately and o_Frame_Count=0 after release.
REQ-036 CLK_DIV=1 -> o_Pix_Stb constant 1 in RUN; X advances every i_Clk cycle.
